// File: rtl/mio_snapshot_master.sv
// MIO bus master: on each frame tick, reads score/position/time, optionally posts
// the pending keycode to a mailbox, then publishes all three values as one snapshot.
module mio_snapshot_master #(
    parameter int unsigned READ_LAT = 0,
    parameter logic [31:0] KEY_ADDR = 32'h0000_0500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic [31:0] addr_bus,
    output logic        mem_w,
    output logic [31:0] Cpu_data2bus,
    input  logic [31:0] Cpu_data4bus,
    input  logic [15:0] key_in,
    input  logic        key_valid,
    output logic [31:0] score_snap,
    output logic [11:0] pos_snap,
    output logic [31:0] time_snap,
    output logic        snap_valid,
    output logic        busy,
    output logic [7:0]  overrun
);
    localparam int unsigned LW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT);

    typedef enum logic [1:0] {IDLE, REQ, ACC, DONE} state_t;

    state_t        state, state_n;
    logic [1:0]    slot, slot_n;
    logic [LW-1:0] lat_cnt, lat_cnt_n;
    logic [31:0]   score_sh, score_sh_n;
    logic [11:0]   pos_sh, pos_sh_n;
    logic [31:0]   time_sh, time_sh_n;
    logic [15:0]   key_buf;
    logic          key_pending;
    logic          key_write;
    logic [31:0]   slot_addr;

    always_comb begin
        case (slot)
            2'd0:    slot_addr = 32'h0000_0100;
            2'd1:    slot_addr = 32'h0000_0200;
            default: slot_addr = 32'h0000_0400;
        endcase
    end

    always_comb begin
        state_n      = state;
        slot_n       = slot;
        lat_cnt_n    = lat_cnt;
        score_sh_n   = score_sh;
        pos_sh_n     = pos_sh;
        time_sh_n    = time_sh;
        bus_req      = 1'b0;
        addr_bus     = '0;
        mem_w        = 1'b0;
        Cpu_data2bus = '0;
        key_write    = 1'b0;
        snap_valid   = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) state_n = REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_n   = ACC;
                    slot_n    = 2'd0;
                    lat_cnt_n = '0;
                end
            end
            ACC: begin
                bus_req = 1'b1;
                if (!bus_gnt) begin
                    // grant lost: the current slot starts over when grant returns
                    lat_cnt_n = '0;
                end else if (slot == 2'd3) begin
                    addr_bus     = KEY_ADDR;
                    mem_w        = 1'b1;
                    Cpu_data2bus = {16'h0, key_buf};
                    key_write    = 1'b1;
                    state_n      = DONE;
                end else begin
                    addr_bus = slot_addr;
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt_n = '0;
                        case (slot)
                            2'd0:    score_sh_n = Cpu_data4bus;
                            2'd1:    pos_sh_n   = Cpu_data4bus[11:0];
                            default: time_sh_n  = Cpu_data4bus;
                        endcase
                        if (slot == 2'd2) begin
                            if (key_pending) slot_n = 2'd3;
                            else             state_n = DONE;
                        end else begin
                            slot_n = slot + 2'd1;
                        end
                    end else begin
                        lat_cnt_n = lat_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                snap_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // no bus transfer may take effect during a reset cycle
        if (rst) begin
            addr_bus     = '0;
            mem_w        = 1'b0;
            Cpu_data2bus = '0;
            key_write    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= 2'd0;
            lat_cnt     <= '0;
            score_sh    <= '0;
            pos_sh      <= '0;
            time_sh     <= '0;
            score_snap  <= '0;
            pos_snap    <= '0;
            time_snap   <= '0;
            key_buf     <= '0;
            key_pending <= 1'b0;
            overrun     <= '0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            lat_cnt  <= lat_cnt_n;
            score_sh <= score_sh_n;
            pos_sh   <= pos_sh_n;
            time_sh  <= time_sh_n;
            // snapshot loads on entry to DONE so it is visible alongside snap_valid
            if (state_n == DONE && state != DONE) begin
                score_snap <= score_sh_n;
                pos_snap   <= pos_sh_n;
                time_snap  <= time_sh_n;
            end
            if (key_valid) begin
                key_buf     <= key_in;
                key_pending <= 1'b1;
            end else if (key_write) begin
                key_pending <= 1'b0;
            end
            if (start && state != IDLE && overrun != 8'hFF)
                overrun <= overrun + 8'd1;
        end
    end
endmodule
